uart_rx_param: RTL and testbench

Parametrised UART receiver: the next generation of the fixed 8-bit, even-parity, two-stop-bit receiver. It adds compile-time data width, stop-bit count and baud divisor, and a run-time parity mode. It also adds start-bit glitch rejection, an input synchronizer, a valid/ready output handshake with overrun detection, and framing/parity flags qualified per frame. It sits between the board RX pin and the CPU's MMIO/DMA UART path.

---
 rtl/uart_pkg.sv | 46 ++++
 rtl/uart_rx_sampler.sv | 59 +++++
 rtl/uart_rx_param.sv | 239 +++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the parametrised UART receiver.
//   parity_mode_t : run-time parity selection (NONE / EVEN / ODD)
//   rx_state_t    : receiver FSM states
//   sample_point  : mid-bit sample offset for a given baud divisor
//   decode_parity_mode, parity_check : parity helpers used by the FSM
package uart_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    EVEN = 2'b01,
    ODD  = 2'b10
  } parity_mode_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  // Sample tick offset inside a bit period (integer division).
  function automatic int sample_point(input int clocks_per_bit);
    return clocks_per_bit / 2;
  endfunction

  // The unused encoding 2'b11 behaves as "no parity".
  function automatic parity_mode_t decode_parity_mode(input logic [1:0] raw);
    case (raw)
      2'b01:   return EVEN;
      2'b10:   return ODD;
      default: return NONE;
    endcase
  endfunction

  // acc is the XOR of all payload bits; rx_bit is the received parity bit.
  function automatic logic parity_check(input parity_mode_t mode, input logic acc,
                                        input logic rx_bit);
    case (mode)
      EVEN:    return acc ^ rx_bit;
      ODD:     return ~(acc ^ rx_bit);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: two-flop synchronizer for the RX pin plus the baud counter
// that produces one sample tick per bit period.
//   clock, clear_n : clock and synchronous active-low reset
//   uart_rx        : raw asynchronous serial line (idle high)
//   i_restart      : FSM has just seen a start edge; realign the bit timing
//   o_rx_s         : synchronized line (second synchronizer stage)
//   o_tick         : mid-bit sample strobe
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 18
) (
  input  logic clock,
  input  logic clear_n,
  input  logic uart_rx,
  input  logic i_restart,
  output logic o_rx_s,
  output logic o_tick
);

  localparam int                SAMPLE_POINT = sample_point(CLOCKS_PER_BIT);
  localparam int                CNT_W        = $clog2(CLOCKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_TICK     = CNT_W'(SAMPLE_POINT);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;

  // Two-stage synchronizer, reset to the idle line level.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rx;
      r_sync2 <= r_sync1;
    end
  end

  // Baud counter. The cycle that detects the start edge counts as position 0,
  // so restart loads 1: the start bit is then sampled SAMPLE_POINT cycles
  // after rx_s first goes low.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_restart) begin
      r_cnt <= CNT_W'(1);
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= {CNT_W{1'b0}};
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_rx_s = r_sync2;
  assign o_tick = (r_cnt == CNT_TICK);

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with start-glitch rejection,
// run-time parity mode, per-frame error flags and a valid/ready output.
//   clock, clear_n  : clock and synchronous active-low reset
//   uart_rx         : asynchronous serial input, idle high
//   parity_mode     : 00 none, 01 even, 10 odd, 11 none (latched per frame)
//   data_out_ready  : consumer accepts the held frame this cycle
//   data_out_valid  : data_out/parity_error/framing_error hold a frame
//   data_out        : received payload (LSB first on the wire)
//   parity_error    : parity mismatch on the held frame
//   framing_error   : a stop bit of the held frame was sampled low
//   overrun         : sticky, a completed frame was dropped; cleared on handshake
//   busy            : receiver is inside a frame
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 18,
  parameter int DATA_BITS      = 8,
  parameter int STOP_BITS      = 2
) (
  input  logic                 clock,
  input  logic                 clear_n,
  input  logic                 uart_rx,
  input  logic [1:0]           parity_mode,
  input  logic                 data_out_ready,
  output logic                 data_out_valid,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam logic [3:0] LAST_DATA_IDX = 4'(DATA_BITS - 1);
  localparam logic       LAST_STOP_IDX = 1'(STOP_BITS - 1);

  logic                 w_rx_s;
  logic                 w_tick;
  logic                 w_restart;
  logic                 w_start_ok;
  logic                 w_shift_en;
  logic                 w_par_en;
  logic                 w_stop_en;
  logic                 w_commit;
  logic                 w_handshake;
  rx_state_t            w_next_state;

  rx_state_t            r_state;
  parity_mode_t         r_mode;
  logic [DATA_BITS-1:0] r_shift;
  logic [3:0]           r_bit_idx;
  logic                 r_stop_idx;
  logic                 r_acc;
  logic                 r_par_err;
  logic                 r_frm_err;
  logic                 r_valid;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_par_flag;
  logic                 r_frm_flag;
  logic                 r_overrun;
  logic                 r_busy;

  uart_rx_sampler #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_sampler (
    .clock    (clock),
    .clear_n  (clear_n),
    .uart_rx  (uart_rx),
    .i_restart(w_restart),
    .o_rx_s   (w_rx_s),
    .o_tick   (w_tick)
  );

  assign w_handshake = r_valid & data_out_ready;

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state and per-tick datapath strobes.
  always_comb begin
    w_next_state = r_state;
    w_restart    = 1'b0;
    w_start_ok   = 1'b0;
    w_shift_en   = 1'b0;
    w_par_en     = 1'b0;
    w_stop_en    = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_next_state = START;
          w_restart    = 1'b1;
        end else begin
          w_next_state = IDLE;
        end
      end
      START: begin
        if (w_tick) begin
          if (w_rx_s) begin
            // Line back high at mid start bit: treat as a glitch.
            w_next_state = IDLE;
          end else begin
            w_next_state = DATA;
            w_start_ok   = 1'b1;
          end
        end else begin
          w_next_state = START;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_shift_en = 1'b1;
          if (r_bit_idx == LAST_DATA_IDX) begin
            if (r_mode != NONE) begin
              w_next_state = PARITY;
            end else begin
              w_next_state = STOP;
            end
          end else begin
            w_next_state = DATA;
          end
        end else begin
          w_next_state = DATA;
        end
      end
      PARITY: begin
        if (w_tick) begin
          w_par_en     = 1'b1;
          w_next_state = STOP;
        end else begin
          w_next_state = PARITY;
        end
      end
      STOP: begin
        if (w_tick) begin
          w_stop_en = 1'b1;
          if (r_stop_idx == LAST_STOP_IDX) begin
            // Straight to IDLE so a start edge inside this bit is not missed.
            w_commit     = 1'b1;
            w_next_state = IDLE;
          end else begin
            w_next_state = STOP;
          end
        end else begin
          w_next_state = STOP;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Frame accumulators: payload shift, running parity and error capture.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      r_mode     <= NONE;
      r_shift    <= {DATA_BITS{1'b0}};
      r_bit_idx  <= 4'd0;
      r_stop_idx <= 1'b0;
      r_acc      <= 1'b0;
      r_par_err  <= 1'b0;
      r_frm_err  <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_mode     <= decode_parity_mode(parity_mode);
        r_shift    <= {DATA_BITS{1'b0}};
        r_bit_idx  <= 4'd0;
        r_stop_idx <= 1'b0;
        r_acc      <= 1'b0;
        r_par_err  <= 1'b0;
        r_frm_err  <= 1'b0;
      end
      if (w_shift_en) begin
        // LSB arrives first; after DATA_BITS shifts it sits at bit 0.
        r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
        r_acc     <= r_acc ^ w_rx_s;
        r_bit_idx <= r_bit_idx + 4'd1;
      end
      if (w_par_en) begin
        r_par_err <= parity_check(r_mode, r_acc, w_rx_s);
      end
      if (w_stop_en) begin
        r_stop_idx <= r_stop_idx + 1'b1;
        if (!w_rx_s) begin
          r_frm_err <= 1'b1;
        end
      end
    end
  end

  // Output holding register with valid/ready handshake and overrun tracking.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      r_valid    <= 1'b0;
      r_data     <= {DATA_BITS{1'b0}};
      r_par_flag <= 1'b0;
      r_frm_flag <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_commit && (!r_valid || w_handshake)) begin
        r_data     <= r_shift;
        r_par_flag <= r_par_err;
        // The final stop sample is still on the line this cycle.
        r_frm_flag <= r_frm_err | ~w_rx_s;
        r_valid    <= 1'b1;
      end else if (w_handshake) begin
        r_valid <= 1'b0;
      end
      if (w_commit && r_valid && !w_handshake) begin
        r_overrun <= 1'b1;
      end else if (w_handshake) begin
        r_overrun <= 1'b0;
      end
    end
  end

  // Busy follows the FSM but is registered from the next state.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= (w_next_state != IDLE);
    end
  end

  assign data_out_valid = r_valid;
  assign data_out       = r_data;
  assign parity_error   = r_par_flag;
  assign framing_error  = r_frm_flag;
  assign overrun        = r_overrun;
  assign busy           = r_busy;

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: an 8-bit and a 7-bit receiver,
// frames built from a bit-level description of the UART line and checked
// against values computed from the frame rules.
module tb_uart_rx_param;

  localparam int CPB = 4;

  logic       clock = 1'b0;
  logic       clear_n;
  logic       rx8, rx7;
  logic [1:0] pm;
  logic       rdy8, rdy7;
  logic       v8, pe8, fe8, ov8, b8;
  logic [7:0] d8;
  logic       v7, pe7, fe7, ov7, b7;
  logic [6:0] d7;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [8:0] data;
    logic       pe;
    logic       fe;
  } rec_t;

  rec_t mon8[$];
  rec_t mon7[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  uart_rx_param #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(2)) dut8 (
    .clock(clock), .clear_n(clear_n), .uart_rx(rx8), .parity_mode(pm),
    .data_out_ready(rdy8), .data_out_valid(v8), .data_out(d8),
    .parity_error(pe8), .framing_error(fe8), .overrun(ov8), .busy(b8));

  uart_rx_param #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2)) dut7 (
    .clock(clock), .clear_n(clear_n), .uart_rx(rx7), .parity_mode(pm),
    .data_out_ready(rdy7), .data_out_valid(v7), .data_out(d7),
    .parity_error(pe7), .framing_error(fe7), .overrun(ov7), .busy(b7));

  function automatic rec_t mk_rec(input int c, input logic [8:0] d, input logic p,
                                  input logic f);
    rec_t r;
    r.cyc  = c;
    r.data = d;
    r.pe   = p;
    r.fe   = f;
    return r;
  endfunction

  // Every accepted frame (valid && ready) is logged with its cycle.
  always @(negedge clock) begin
    if (v8 && rdy8) mon8.push_back(mk_rec(cyc, {1'b0, d8}, pe8, fe8));
    if (v7 && rdy7) mon7.push_back(mk_rec(cyc, {2'b00, d7}, pe7, fe7));
  end

  // ---------------- reference model ----------------
  function automatic int ones(input logic [8:0] d, input int nbits);
    int n = 0;
    for (int i = 0; i < nbits; i++) n += int'(d[i]);
    return n;
  endfunction

  function automatic bit has_parity(input logic [1:0] mode);
    return (mode == 2'b01) || (mode == 2'b10);
  endfunction

  function automatic int frame_len(input int nbits, input logic [1:0] mode);
    return 1 + nbits + (has_parity(mode) ? 1 : 0) + 2;
  endfunction

  // Cycles from the line's falling edge to the first valid cycle.
  function automatic int latency(input int f);
    return 2 + CPB / 2 + (f - 1) * CPB + 1;
  endfunction

  // Even: total ones (payload + parity bit) must be even; odd: must be odd.
  function automatic logic exp_pe(input logic [8:0] d, input int nbits,
                                  input logic [1:0] mode, input logic pbit);
    int n;
    n = ones(d, nbits) + int'(pbit);
    if (mode == 2'b01) return (n % 2) != 0;
    if (mode == 2'b10) return (n % 2) != 1;
    return 1'b0;
  endfunction

  task automatic set_line(input int which, input logic b);
    if (which == 8) rx8 = b;
    else rx7 = b;
  endtask

  // Drive one frame: start, payload LSB first, optional parity bit, two stop
  // bits (stop_vals[0] first), then an idle gap. parity_mode changes to
  // pm_mid partway through the payload.
  task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                            input logic [1:0] mode, input logic pbit,
                            input logic [1:0] stop_vals, input logic [1:0] pm_mid,
                            output int start_cyc);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < nbits; i++) bits.push_back(data[i]);
    if (has_parity(mode)) bits.push_back(pbit);
    bits.push_back(stop_vals[0]);
    bits.push_back(stop_vals[1]);
    pm = mode;
    @(posedge clock); #1;
    start_cyc = cyc;
    for (int i = 0; i < bits.size(); i++) begin
      set_line(which, bits[i]);
      if (i == 2) pm = pm_mid;
      repeat (CPB) @(posedge clock);
      #1;
    end
    set_line(which, 1'b1);
    repeat (2 * CPB) @(posedge clock);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    clear_n = 1'b0; rx8 = 1'b1; rx7 = 1'b1; rdy8 = 1'b1; rdy7 = 1'b1; pm = 2'b00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({v8, d8, pe8, fe8, ov8, b8} !== 13'd0) begin
      errors++;
      $display("FAIL reset8: got %h expected %h", {v8, d8, pe8, fe8, ov8, b8}, 13'd0);
    end
    checks++;
    if ({v7, d7, pe7, fe7, ov7, b7} !== 12'd0) begin
      errors++;
      $display("FAIL reset7: got %h expected %h", {v7, d7, pe7, fe7, ov7, b7}, 12'd0);
    end
    @(posedge clock); #1;
    clear_n = 1'b1;
    repeat (3) @(posedge clock);
  endtask

  task automatic test_even;
    int s;
    rec_t r;
    mon8.delete();
    send_frame(8, 9'h0A5, 8, 2'b01, 1'b0, 2'b11, 2'b01, s);
    checks++;
    if (mon8.size() !== 1) begin
      errors++;
      $display("FAIL even_count: got %0d expected %0d", mon8.size(), 1);
    end else begin
      r = mon8[0];
      checks++;
      if ({r.data, r.pe, r.fe} !== {9'h0A5, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL even_frame: got %h/%b/%b expected a5/0/0", r.data, r.pe, r.fe);
      end
      checks++;
      if (r.cyc !== s + latency(frame_len(8, 2'b01))) begin
        errors++;
        $display("FAIL even_latency: got %0d expected %0d", r.cyc - s,
                 latency(frame_len(8, 2'b01)));
      end
    end
  endtask

  task automatic test_odd;
    int s;
    logic pbits[2];
    pbits[0] = 1'b0;
    pbits[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      mon8.delete();
      send_frame(8, 9'h03C, 8, 2'b10, pbits[k], 2'b11, 2'b10, s);
      checks++;
      if (mon8.size() !== 1) begin
        errors++;
        $display("FAIL odd_count%0d: got %0d expected %0d", k, mon8.size(), 1);
      end else if ({mon8[0].data, mon8[0].pe} !==
                   {9'h03C, exp_pe(9'h03C, 8, 2'b10, pbits[k])}) begin
        errors++;
        $display("FAIL odd_frame%0d: got %h/%b expected 3c/%b", k, mon8[0].data,
                 mon8[0].pe, exp_pe(9'h03C, 8, 2'b10, pbits[k]));
      end
    end
  endtask

  task automatic test_none7;
    int s;
    mon7.delete();
    send_frame(7, 9'h055, 7, 2'b00, 1'b0, 2'b01, 2'b00, s);
    checks++;
    if (mon7.size() !== 1) begin
      errors++;
      $display("FAIL none7_count: got %0d expected %0d", mon7.size(), 1);
    end else begin
      checks++;
      if ({mon7[0].data, mon7[0].pe, mon7[0].fe} !== {9'h055, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL none7_frame: got %h/%b/%b expected 55/0/1", mon7[0].data,
                 mon7[0].pe, mon7[0].fe);
      end
      checks++;
      if (mon7[0].cyc !== s + latency(frame_len(7, 2'b00))) begin
        errors++;
        $display("FAIL none7_latency: got %0d expected %0d", mon7[0].cyc - s,
                 latency(frame_len(7, 2'b00)));
      end
    end
  endtask

  task automatic test_glitch;
    int busy_cycles = 0;
    int valid_cycles = 0;
    @(posedge clock); #1;
    rx8 = 1'b0;
    @(posedge clock); #1;
    rx8 = 1'b1;
    repeat (4 * CPB) begin
      @(negedge clock);
      if (b8) busy_cycles++;
      if (v8) valid_cycles++;
    end
    checks++;
    if (busy_cycles !== CPB / 2) begin
      errors++;
      $display("FAIL glitch_busy: got %0d expected %0d", busy_cycles, CPB / 2);
    end
    checks++;
    if ({valid_cycles, b8} !== {32'd0, 1'b0}) begin
      errors++;
      $display("FAIL glitch_idle: got valid=%0d busy=%b expected 0/0", valid_cycles, b8);
    end
  endtask

  task automatic test_overrun;
    int s;
    rdy8 = 1'b0;
    mon8.delete();
    send_frame(8, 9'h011, 8, 2'b01, 1'b0, 2'b11, 2'b01, s);
    send_frame(8, 9'h022, 8, 2'b01, 1'b0, 2'b11, 2'b01, s);
    @(negedge clock);
    checks++;
    if ({v8, d8, ov8} !== {1'b1, 8'h11, 1'b1}) begin
      errors++;
      $display("FAIL overrun_hold: got %b/%h/%b expected 1/11/1", v8, d8, ov8);
    end
    @(posedge clock); #1;
    rdy8 = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if ({v8, ov8} !== 2'b00) begin
      errors++;
      $display("FAIL overrun_release: got %b/%b expected 0/0", v8, ov8);
    end
    checks++;
    if (mon8.size() !== 1 || mon8[0].data !== 9'h011) begin
      errors++;
      $display("FAIL overrun_accept: got %0d frames expected 1 frame of 11", mon8.size());
    end
  endtask

  task automatic test_reset_mid;
    int s;
    rdy8 = 1'b0;
    send_frame(8, 9'h077, 8, 2'b01, 1'b0, 2'b11, 2'b01, s);
    @(posedge clock); #1;
    pm = 2'b01;
    rx8 = 1'b0;
    repeat (CPB) @(posedge clock);
    #1;
    rx8 = 1'b1;
    repeat (3 * CPB) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({v8, b8} !== 2'b11) begin
      errors++;
      $display("FAIL midreset_pre: got %b/%b expected 1/1", v8, b8);
    end
    @(posedge clock); #1;
    clear_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if ({v8, d8, pe8, fe8, ov8, b8} !== 13'd0) begin
      errors++;
      $display("FAIL midreset_clear: got %h expected %h", {v8, d8, pe8, fe8, ov8, b8}, 13'd0);
    end
    @(posedge clock); #1;
    clear_n = 1'b1;
    rdy8 = 1'b1;
    repeat (2) @(posedge clock);
    mon8.delete();
    send_frame(8, 9'h05A, 8, 2'b01, 1'b0, 2'b11, 2'b01, s);
    checks++;
    if (mon8.size() !== 1 || {mon8[0].data, mon8[0].pe, mon8[0].fe} !== {9'h05A, 1'b0, 1'b0})
    begin
      errors++;
      $display("FAIL midreset_after: got %0d frames expected 1 frame of 5a/0/0", mon8.size());
    end
  endtask

  task automatic test_random;
    int         s;
    logic [8:0] d;
    logic [1:0] mode, st, mid;
    logic       pbit;
    for (int k = 0; k < 12; k++) begin
      d    = 9'($urandom_range(0, 255));
      mode = 2'($urandom_range(0, 3));
      mid  = 2'($urandom_range(0, 3));
      pbit = 1'($urandom_range(0, 1));
      st   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      mon8.delete();
      send_frame(8, d, 8, mode, pbit, st, mid, s);
      checks++;
      if (mon8.size() !== 1) begin
        errors++;
        $display("FAIL rand%0d_count: got %0d expected %0d", k, mon8.size(), 1);
      end else if ({mon8[0].data, mon8[0].pe, mon8[0].fe} !==
                   {d, exp_pe(d, 8, mode, pbit), st != 2'b11}) begin
        errors++;
        $display("FAIL rand%0d_frame: got %h/%b/%b expected %h/%b/%b", k, mon8[0].data,
                 mon8[0].pe, mon8[0].fe, d, exp_pe(d, 8, mode, pbit), st != 2'b11);
      end else if (mon8[0].cyc !== s + latency(frame_len(8, mode))) begin
        errors++;
        $display("FAIL rand%0d_latency: got %0d expected %0d", k, mon8[0].cyc - s,
                 latency(frame_len(8, mode)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_even();
    test_odd();
    test_none7();
    test_glitch();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
